skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width in bits (legal 1..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-005 SHALL have port in_ready  output  1  buffer accepts; registered, not combinationally dependent on out_ready.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid word; registered.
REQ-008 SHALL have port out_ready  input  1  downstream accepts.
REQ-009 SHALL have port out_data  output  WIDTH  downstream payload; registered.
REQ-010 SHALL have port xfer_count  output  16  count of completed output transfers.

Function
REQ-011 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready, evaluated each rising clk edge.
REQ-012 SHALL implement three states: EMPTY (no word), ONE (main register full), FULL (main and skid registers full).
REQ-013 SHALL drive out_valid=1 in ONE and FULL, 0 in EMPTY; in_ready=1 in EMPTY and ONE, 0 in FULL.
REQ-014 SHALL transition EMPTY->ONE on push, loading in_data into main; latency in_valid to out_valid exactly 1 cycle.
REQ-015 SHALL in ONE: push&&pop -> stay ONE, main <= in_data; pop only -> EMPTY; push only -> FULL, skid <= in_data; neither -> hold.
REQ-016 SHALL in FULL: pop -> ONE, main <= skid; no pop -> hold; push impossible since in_ready=0.
REQ-017 SHALL deliver words in strict acceptance order with no loss or duplication.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL sustain one transfer per cycle when in_valid and out_ready are both continuously 1.
REQ-020 SHALL increment xfer_count by 1 on each pop, wrapping 16'hFFFF -> 16'h0000.
REQ-021 SHALL ignore in_data when in_valid=0 and ignore out_ready when out_valid=0.

Reset
REQ-022 SHALL on rst_n=0 immediately force state EMPTY, out_valid=0, in_ready=0, out_data=0, xfer_count=0, skid=0.
REQ-023 SHALL raise in_ready to 1 on the first rising clk edge after rst_n deasserts.
REQ-024 SHALL discard any buffered words when reset asserts mid-operation; no partial transfer completes.

Configuration
REQ-025 SHALL use macro SKID_BUFFER_FORMAL_CHECKS_EN to include embedded formal assertions under the FORMAL tool flow.
REQ-026 SHALL, with macro defined, assert after reset: REQ-018 stability, no FULL->push, state encoding always legal, in_ready == (state != FULL).
REQ-027 SHALL, with macro undefined, contain no assertion logic; ports, timing and function identical.
REQ-028 SHALL produce identical synthesised netlists regardless of the macro under a SYNTHESIS flow.

Verification
REQ-029 SHALL cover: reset release, in_valid=1 data 8'hA5, out_ready=1 -> out_valid=1 with 8'hA5 next cycle, xfer_count=1.
REQ-030 SHALL cover: out_ready=0, push 8'h11 then 8'h22 -> in_ready=0 after second push; out_data holds 8'h11.
REQ-031 SHALL cover: from FULL raise out_ready for 2 cycles -> outputs 8'h11 then 8'h22, state EMPTY, in_ready=1.
REQ-032 SHALL cover: streaming 100 incrementing words with out_ready=1 -> 100 words in order, one per cycle, xfer_count=100.
REQ-033 SHALL cover: xfer_count preset path via 65536 pops -> xfer_count wraps to 0.
REQ-034 SHALL cover: rst_n low while FULL -> out_valid=0 and xfer_count=0 same cycle without clk edge.

Source files
------------

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready pipeline stage with fully registered
// handshake outputs. A main register feeds out_data; a skid register catches
// the one extra word accepted in the cycle downstream stalls, so in_ready
// never depends combinationally on out_ready.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream offers in_data
//   in_ready   - buffer can accept a word (registered)
//   in_data    - upstream payload, WIDTH bits
//   out_valid  - out_data holds a valid word (registered)
//   out_ready  - downstream accepts
//   out_data   - downstream payload (registered)
//   xfer_count - 16-bit wrapping count of completed output transfers
//
// Optional: define SKID_BUFFER_FORMAL_CHECKS_EN to embed formal assertions.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      xfer_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic             push_c, pop_c;

  // Handshakes qualified by the registered flags.
  assign push_c = in_valid && in_ready_q;
  assign pop_c  = out_valid_q && out_ready;

  // Next-state, datapath and registered-flag computation.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    xfer_d  = xfer_q;

    if (pop_c) begin
      xfer_d = xfer_q + CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (push_c) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (push_c && pop_c) begin
          main_d = in_data;
        end else if (pop_c) begin
          state_d = EMPTY;
        end else if (push_c) begin
          state_d = FULL;
          skid_d  = in_data;
        end
      end
      FULL: begin
        if (pop_c) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flags derive from the next state so they are flops, not decode.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State and datapath registers; in_ready stays low until the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      xfer_q      <= xfer_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_q;
  assign xfer_count = xfer_q;

`ifdef SKID_BUFFER_FORMAL_CHECKS_EN
`ifndef SYNTHESIS
  // Marks that one edge has passed since reset, when in_ready becomes live.
  logic init_done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(main_q)));

  a_no_full_push: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == FULL) |-> !push_c);

  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q inside {EMPTY, ONE, FULL}));

  a_ready_match: assert property (@(posedge clk) disable iff (!rst_n)
    init_done_q |-> (in_ready_q == (state_q != FULL)));
`endif
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed scenarios plus randomized
// traffic compared against a queue-based model of the buffer.
module tb_skid_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] xfer_count;

  int n_cmp;
  int n_err;

  // Reference model: FIFO of at most two accepted words.
  logic [7:0]  mq[$];
  logic        m_in_ready;
  logic [15:0] m_xfer;

  skid_buffer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_in_ready = 1'b0;
    m_xfer     = 16'd0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy);
    logic push, pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    push = iv && m_in_ready;
    pop  = (mq.size() > 0) && ordy;
    if (pop) begin
      void'(mq.pop_front());
      m_xfer = m_xfer + 16'd1;
    end
    if (push) mq.push_back(id);
    m_in_ready = (mq.size() < 2);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_cmp++; if (xfer_count !== 16'h0) begin n_err++; $display("FAIL reset_xfer got=%h exp=0000", xfer_count); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_early got=%b exp=0", in_ready); end
    step(1'b0, 8'h00, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready_rise got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    step(1'b1, 8'hA5, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_err++; $display("FAIL single_out got=%b/%h exp=1/a5", out_valid, out_data); end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL single_xfer got=%0d exp=1", xfer_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin n_err++; $display("FAIL fill_out got=%b/%h exp=1/11", out_valid, out_data); end
    // Offer a word while full: must be ignored and outputs held.
    step(1'b1, 8'h33, 1'b0);
    n_cmp++; if (out_data !== 8'h11 || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL fill_hold got=%b/%h/%b exp=1/11/0", out_valid, out_data, in_ready); end
  endtask

  task automatic test_drain();
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin n_err++; $display("FAIL drain_second got=%b/%h exp=1/22", out_valid, out_data); end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_stream();
    int bad;
    bad = 0;
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(i), 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || in_ready !== 1'b1) begin
        n_err++; bad++;
        if (bad < 5) $display("FAIL stream_word[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (xfer_count !== 16'd100) begin n_err++; $display("FAIL stream_xfer got=%0d exp=100", xfer_count); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0 ? 1 : 0));
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || in_ready !== m_in_ready || xfer_count !== m_xfer ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        n_err++; bad++;
        if (bad < 5) $display("FAIL random[%0d] got v=%b d=%h r=%b x=%0d exp v=%b d=%h r=%b x=%0d",
          i, out_valid, out_data, in_ready, xfer_count, mq.size() > 0,
          (mq.size() > 0) ? mq[0] : 8'h00, m_in_ready, m_xfer);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 65536; i++) step(1'b1, 8'(i), 1'b1);
    n_cmp++; if (xfer_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got=%h exp=ffff", xfer_count); end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (xfer_count !== 16'h0000 || xfer_count !== m_xfer) begin n_err++; $display("FAIL wrap_zero got=%h exp=0000", xfer_count); end
  endtask

  task automatic test_reset_full();
    do_reset();
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h05, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h06, 1'b0);
    step(1'b1, 8'h07, 1'b0);
    n_cmp++; if (in_ready !== 1'b0 || xfer_count !== 16'd1) begin n_err++; $display("FAIL rfull_setup got=%b/%0d exp=0/1", in_ready, xfer_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || xfer_count !== 16'd0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
      n_err++; $display("FAIL rfull_async got=%b/%0d/%b/%h exp=0/0/0/00", out_valid, xfer_count, in_ready, out_data);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_count !== 16'd0) begin n_err++; $display("FAIL rfull_after got=%b/%b/%0d exp=0/1/0", out_valid, in_ready, xfer_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    test_wrap();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
